// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_rr_arbiter_pkg
//   Shared definitions for the round-robin FIFO arbiter: FSM state
//   encodings, the fixed source-FIFO count, the default word width and the
//   round-robin pointer helper.
package fifo_rr_arbiter_pkg;

  localparam int NUM_FIFOS         = 5;
  localparam int DATA_SIZE_DEFAULT = 12;
  localparam int PTR_W             = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    STALL = 2'd2
  } state_t;

  // Pointer to the FIFO after grant g, wrapping from the last FIFO to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    return (g == PTR_W'(NUM_FIFOS - 1)) ? '0 : g + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if
//   Bundles the source-FIFO, sink-FIFO and status signals of the arbiter.
//   empty/data_in      : per-source empty flags and show-ahead head words
//   out_almost_full    : sink cannot take another word
//   pop0..pop4         : pop strobes to the source FIFOs
//   push/data_out      : write strobe and word to the sink FIFO
//   idle               : no work pending
//   master = arbiter side, slave = FIFO/environment side.
interface fifo_rr_arbiter_if #(
  parameter int DATA_SIZE = fifo_rr_arbiter_pkg::DATA_SIZE_DEFAULT
);
  import fifo_rr_arbiter_pkg::*;

  logic [NUM_FIFOS-1:0]           empty;
  logic [NUM_FIFOS*DATA_SIZE-1:0] data_in;
  logic                           out_almost_full;
  logic                           pop0;
  logic                           pop1;
  logic                           pop2;
  logic                           pop3;
  logic                           pop4;
  logic                           push;
  logic [DATA_SIZE-1:0]           data_out;
  logic                           idle;

  modport master (
    input  empty, data_in, out_almost_full,
    output pop0, pop1, pop2, pop3, pop4, push, data_out, idle
  );

  modport slave (
    output empty, data_in, out_almost_full,
    input  pop0, pop1, pop2, pop3, pop4, push, data_out, idle
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_select.sv
// rr_select
//   Combinational round-robin selector. Grants the first requester at or
//   after ptr_i, searching ptr_i, ptr_i+1, ... modulo NUM_FIFOS.
//   req_i : request vector (one bit per source FIFO)
//   ptr_i : round-robin start pointer
//   gnt_o : one-hot grant (all zero when nothing requests)
//   idx_o : index of the granted FIFO (0 when nothing requests)
module rr_select
  import fifo_rr_arbiter_pkg::*;
(
  input  logic [NUM_FIFOS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_FIFOS-1:0] gnt_o,
  output logic [PTR_W-1:0]     idx_o
);

  logic             found;
  logic [PTR_W-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      pos = PTR_W'((32'(ptr_i) + k) % NUM_FIFOS);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Moves words from five show-ahead source FIFOs into one sink FIFO,
//   one word per cycle, in round-robin order.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fifo_rr_arbiter_if master modport (empty, data_in,
//           out_almost_full in; pop0..pop4, push, data_out, idle out)
//   Pops are combinational from the registered state; the popped word is
//   registered into data_out and pushed exactly one cycle later.
module fifo_rr_arbiter #(
  parameter int DATA_SIZE = fifo_rr_arbiter_pkg::DATA_SIZE_DEFAULT,
  parameter int NUM_FIFOS = fifo_rr_arbiter_pkg::NUM_FIFOS
) (
  input logic                clk,
  input logic                reset,
  fifo_rr_arbiter_if.master  bus
);
  import fifo_rr_arbiter_pkg::PTR_W;
  import fifo_rr_arbiter_pkg::state_t;
  import fifo_rr_arbiter_pkg::IDLE;
  import fifo_rr_arbiter_pkg::ARB;
  import fifo_rr_arbiter_pkg::STALL;
  import fifo_rr_arbiter_pkg::next_ptr;

  state_t                              state_q, state_d;
  logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic                                push_q, push_d;
  logic [DATA_SIZE-1:0]                data_q, data_d;
  logic                                idle_q, idle_d;

  logic [NUM_FIFOS-1:0]                req, gnt, pop;
  logic [PTR_W-1:0]                    gnt_idx;
  logic                                any_req, all_empty, pop_en;
  logic [NUM_FIFOS-1:0][DATA_SIZE-1:0] words;

  assign req       = ~bus.empty;
  assign any_req   = |req;
  assign all_empty = &bus.empty;
  assign words     = bus.data_in;

  rr_select u_rr_select (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = bus.out_almost_full ? STALL : ARB;
      end
      ARB: begin
        if (bus.out_almost_full) state_d = STALL;
        else if (!any_req)       state_d = IDLE;
      end
      STALL: begin
        if (!bus.out_almost_full) state_d = any_req ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The selector only grants requesters, so a granted FIFO is never empty.
  always_comb begin
    pop_en   = (state_q == ARB) && !bus.out_almost_full && any_req && !reset;
    pop      = pop_en ? gnt : '0;
    push_d   = pop_en;
    data_d   = pop_en ? words[gnt_idx] : data_q;
    rr_ptr_d = pop_en ? next_ptr(gnt_idx) : rr_ptr_q;
    idle_d   = (state_d == IDLE) && !pop_en && all_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      push_q   <= 1'b0;
      data_q   <= '0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      push_q   <= push_d;
      data_q   <= data_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.pop0     = pop[0];
  assign bus.pop1     = pop[1];
  assign bus.pop2     = pop[2];
  assign bus.pop3     = pop[3];
  assign bus.pop4     = pop[4];
  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign bus.idle     = idle_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter
//   Directed bench for fifo_rr_arbiter. Source FIFOs are queues driven at
//   the falling edge; pops are sampled 1 time unit later, registered
//   outputs are sampled at the next falling edge.
module tb_fifo_rr_arbiter;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.DATA_SIZE(DW)) bus ();

  fifo_rr_arbiter #(
    .DATA_SIZE (DW),
    .NUM_FIFOS (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0]        fq [5][$];
  int                   cnt [5];
  int                   n_assert = 0;
  int                   n_fail   = 0;
  logic [4:0]           popv;
  logic [4:0][DW-1:0]   din;

  function automatic logic [DW-1:0] w(input int i, input int k);
    return DW'((i + 1) * 256 + k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) fq[3'(i)].push_back(w(i, k));
  endtask

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      bus.empty[3'(i)] = (fq[3'(i)].size() == 0);
      din[3'(i)]       = (fq[3'(i)].size() == 0) ? 12'hEEE : fq[3'(i)][0];
    end
    bus.data_in = din;
  endtask

  // One clock cycle: present inputs, check pop strobes, consume popped words.
  task automatic step(input logic [4:0] exp_pop, input string tag);
    drive();
    #1;
    popv = {bus.pop4, bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    check({tag, ".pop"}, 32'(popv), 32'(exp_pop));
    for (int i = 0; i < 5; i++) begin
      if (popv[3'(i)] && fq[3'(i)].size() != 0) begin
        void'(fq[3'(i)].pop_front());
        cnt[3'(i)]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic post(input string tag, input logic ep, input logic [DW-1:0] ed, input logic ei);
    check({tag, ".push"}, 32'(bus.push), 32'(ep));
    check({tag, ".data"}, 32'(bus.data_out), 32'(ed));
    check({tag, ".idle"}, 32'(bus.idle), 32'(ei));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) cnt[3'(i)] = 0;
    reset = 1'b1;
    bus.out_almost_full = 1'b0;
    drive();
    @(negedge clk);

    // Reset state
    step(5'b00000, "rst");
    post("rst", 1'b0, 12'h000, 1'b1);
    reset = 1'b0;

    // Scenario 1: all FIFOs hold 2 words
    for (int i = 0; i < 5; i++) load(i, 2);
    step(5'b00000, "s1.enter");
    post("s1.enter", 1'b0, 12'h000, 1'b0);
    for (int j = 0; j < 10; j++) begin
      step(5'(1 << (j % 5)), "s1.run");
      post("s1.run", 1'b1, w(j % 5, j / 5), 1'b0);
    end
    step(5'b00000, "s1.drain");
    post("s1.drain", 1'b0, w(4, 1), 1'b1);
    for (int i = 0; i < 5; i++) check("s1.cnt", 32'(cnt[3'(i)]), 32'd2);

    // Scenario 2: only FIFO 3 non-empty, rr_ptr = 0
    load(3, 3);
    step(5'b00000, "s2.enter");
    post("s2.enter", 1'b0, w(4, 1), 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(5'b01000, "s2.run");
      post("s2.run", 1'b1, w(3, k), 1'b0);
    end
    step(5'b00000, "s2.drain");
    post("s2.drain", 1'b0, w(3, 2), 1'b1);

    // Scenario 3: out_almost_full rises while popping FIFO 1 (rr_ptr = 4)
    load(1, 2);
    load(2, 2);
    step(5'b00000, "s3.enter");
    post("s3.enter", 1'b0, w(3, 2), 1'b0);
    step(5'b00010, "s3.pop1");
    post("s3.pop1", 1'b1, w(1, 0), 1'b0);
    bus.out_almost_full = 1'b1;
    step(5'b00000, "s3.af_rise");
    post("s3.af_rise", 1'b0, w(1, 0), 1'b0);
    step(5'b00000, "s3.stall");
    post("s3.stall", 1'b0, w(1, 0), 1'b0);
    bus.out_almost_full = 1'b0;
    step(5'b00000, "s3.af_fall");
    post("s3.af_fall", 1'b0, w(1, 0), 1'b0);
    step(5'b00100, "s3.resume2");
    post("s3.resume2", 1'b1, w(2, 0), 1'b0);
    step(5'b00010, "s3.next1");
    post("s3.next1", 1'b1, w(1, 1), 1'b0);
    step(5'b00100, "s3.next2");
    post("s3.next2", 1'b1, w(2, 1), 1'b0);
    step(5'b00000, "s3.drain");
    post("s3.drain", 1'b0, w(2, 1), 1'b1);

    // Scenario 4: IDLE->STALL entry, then grant 4 wraps to 0 (rr_ptr = 3)
    load(0, 1);
    load(4, 1);
    bus.out_almost_full = 1'b1;
    step(5'b00000, "s4.stall");
    post("s4.stall", 1'b0, w(2, 1), 1'b0);
    bus.out_almost_full = 1'b0;
    step(5'b00000, "s4.unstall");
    post("s4.unstall", 1'b0, w(2, 1), 1'b0);
    step(5'b10000, "s4.pop4");
    post("s4.pop4", 1'b1, w(4, 0), 1'b0);
    step(5'b00001, "s4.wrap0");
    post("s4.wrap0", 1'b1, w(0, 0), 1'b0);
    step(5'b00000, "s4.drain");
    post("s4.drain", 1'b0, w(0, 0), 1'b1);

    // Scenario 5: reset the cycle after a pop (rr_ptr = 1)
    load(2, 2);
    load(4, 1);
    step(5'b00000, "s5.enter");
    post("s5.enter", 1'b0, w(0, 0), 1'b0);
    step(5'b00100, "s5.pop2");
    post("s5.pop2", 1'b1, w(2, 0), 1'b0);
    reset = 1'b1;
    step(5'b00000, "s5.reset");
    post("s5.reset", 1'b0, 12'h000, 1'b1);
    reset = 1'b0;
    step(5'b00000, "s5.reenter");
    post("s5.reenter", 1'b0, 12'h000, 1'b0);
    step(5'b00100, "s5.lowest");
    post("s5.lowest", 1'b1, w(2, 1), 1'b0);
    step(5'b10000, "s5.pop4");
    post("s5.pop4", 1'b1, w(4, 0), 1'b0);
    step(5'b00000, "s5.drain");
    post("s5.drain", 1'b0, w(4, 0), 1'b1);

    // Scenario 6: all empty for 20 cycles
    for (int c = 0; c < 20; c++) begin
      step(5'b00000, "s6.empty");
      post("s6.empty", 1'b0, w(4, 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock is clk; reset is reset, synchronous and active-high.
REQ-002 Parameter DATA_SIZE, default 12, SHALL set the word width.
REQ-003 Parameter NUM_FIFOS, default 5, SHALL set the source FIFO count; only the value 5 is supported.
REQ-004 The ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- empty  in  5  empty flag per source FIFO; bit i belongs to FIFO i.
- data_in  in  5*DATA_SIZE  show-ahead head word per FIFO; FIFO i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- out_almost_full  in  1  sink FIFO cannot take another word.
- pop0..pop4  out  1 each  pop strobe to source FIFO 0..4; these also feed the downstream pop counter.
- push  out  1  write strobe to the sink FIFO.
- data_out  out  DATA_SIZE  word written to the sink.
- idle  out  1  no work pending.

Function
REQ-005 The FSM SHALL have three states: IDLE, ARB and STALL.
REQ-006 IDLE SHALL go to ARB when any empty bit is 0 and out_almost_full is 0.
REQ-007 IDLE SHALL go to STALL when any empty bit is 0 and out_almost_full is 1.
REQ-008 ARB SHALL go to STALL when out_almost_full is 1.
REQ-009 ARB SHALL go to IDLE when all empty bits are 1.
REQ-010 STALL SHALL go to ARB when out_almost_full is 0 and any empty bit is 0.
REQ-011 STALL SHALL go to IDLE when out_almost_full is 0 and all empty bits are 1.
REQ-012 Pop strobes SHALL be combinational and registered-state based: asserted only in state ARB, with out_almost_full 0 and the selected FIFO's empty bit 0.
REQ-013 At most one pop strobe SHALL be high in any cycle (one-hot or all zero).
REQ-014 Selection SHALL be round-robin: grant the first non-empty FIFO at or after a 3-bit pointer rr_ptr, searching in order ptr, ptr+1, ... mod 5.
REQ-015 After a grant to FIFO g, rr_ptr SHALL become (g+1) mod 5.
REQ-016 rr_ptr SHALL be unchanged in any cycle without a grant, and SHALL never hold values 5..7.
REQ-017 In the cycle FIFO g is popped, data_in slice g SHALL be registered into data_out, and push SHALL be 1 in the following cycle.
REQ-018 Latency from pop to push SHALL be exactly 1 cycle, and data_out SHALL hold its value when push is 0.
REQ-019 Sustained throughput SHALL be one word per cycle while any source is non-empty and the sink is not almost full.
REQ-020 out_almost_full rising SHALL block new pops in the same cycle, while a push already scheduled from the previous pop still completes.
REQ-021 A FIFO whose empty bit is 1 SHALL never be popped, even when rr_ptr points at it; it is skipped.
REQ-022 rr_ptr wrap-around SHALL select FIFO 0 next, e.g. a grant to FIFO 4 sets rr_ptr to 0.
REQ-023 idle SHALL be registered and equal 1 exactly when the state is IDLE, push is 0 and all empty bits are 1.
REQ-024 Unknown state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-025 While reset is 1 at a clk edge, the block SHALL set: state IDLE, rr_ptr 0, push 0, data_out 0, idle 1, and all pop strobes 0 combinationally.
REQ-026 Reset asserted mid-transfer SHALL discard any pending push, with no push in the cycle after reset.
REQ-027 Pops SHALL be forced to 0 during any cycle in which reset is 1.

Structure
REQ-028 A shared package SHALL hold the state encodings (IDLE=0, ARB=1, STALL=2), NUM_FIFOS and the default DATA_SIZE.
REQ-029 One sub-module, rr_select, SHALL be used: combinational; inputs are the 5-bit request (~empty) and rr_ptr; outputs are the one-hot grant and the grant index.
REQ-030 The arbiter SHALL contain only the FSM, rr_ptr, the output register and the idle register.

Verification
REQ-031 The bench SHALL compare the RTL against the synthesized netlist cycle by cycle on every output, and SHALL feed pop0..pop4 to the pop counter to check counts.
REQ-032 Scenario 1: all FIFOs hold 2 words, sink free -> pops in order 0,1,2,3,4,0,1,2,3,4; 10 pushes; each FIFO counted 2 by the counter; idle returns to 1 two cycles after the last pop.
REQ-033 Scenario 2: only FIFO 3 is non-empty (3 words) with rr_ptr=0 -> pop3 on three consecutive cycles; data_out is the 3 words in order, each one cycle after its pop.
REQ-034 Scenario 3: out_almost_full rises while popping FIFO 1 -> next cycle no pop and a single push of FIFO 1's word; when it falls, the pop resumes at FIFO 2.
REQ-035 Scenario 4: a grant to FIFO 4 occurs with FIFOs 0 and 4 non-empty -> the next grant is FIFO 0 (wrap check).
REQ-036 Scenario 5: reset asserted the cycle after a pop -> no push; data_out=0; idle=1; rr_ptr=0; the first grant after reset goes to the lowest non-empty FIFO.
REQ-037 Scenario 6: all FIFOs empty for 20 cycles -> no pop, no push, and idle stays 1.
